// File: rtl/move_link_if.sv
// Bundle of the game_fsm, rx and tx facing signals of move_link.
// The slave modport is the link itself; the master drives it.
interface move_link_if;
    logic       send_in;
    logic [7:0] move_in;
    logic       rx_ready_in;
    logic [7:0] rx_byte_in;
    logic       tx_trigger_out;
    logic [7:0] tx_byte_out;
    logic       move_valid_out;
    logic [7:0] move_out;
    logic       link_busy_out;
    logic       link_fail_out;

    modport master (
        output send_in, move_in, rx_ready_in, rx_byte_in,
        input  tx_trigger_out, tx_byte_out, move_valid_out, move_out,
        input  link_busy_out, link_fail_out
    );

    modport slave (
        input  send_in, move_in, rx_ready_in, rx_byte_in,
        output tx_trigger_out, tx_byte_out, move_valid_out, move_out,
        output link_busy_out, link_fail_out
    );
endinterface

// File: rtl/move_link.sv
// Reliable move exchange over a shared UART byte port: sequenced data frames
// with retransmission, acked and de-duplicated inbound frames, byte pacing.
module move_link #(
    parameter int unsigned BYTE_GAP_CYC    = 74_481,
    parameter int unsigned ACK_TIMEOUT_CYC = 6_500_000,
    parameter int unsigned MAX_RETRIES     = 7
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    move_link_if.slave lnk
);
    localparam int unsigned GAP_W = $clog2(BYTE_GAP_CYC + 1);
    localparam int unsigned TO_W  = $clog2(ACK_TIMEOUT_CYC + 1);
    localparam int unsigned RXT_W = $clog2(2 * BYTE_GAP_CYC + 1);
    localparam int unsigned RET_W = $clog2(MAX_RETRIES + 2);
    localparam logic [6:0]  DATA_PFX = 7'b1010_000;
    localparam logic [6:0]  ACK_PFX  = 7'b1100_000;

    typedef enum logic [1:0] {IDLE, HDR, MOVE, WAIT_ACK} tx_state_e;
    typedef enum logic       {R_IDLE, R_MOVE} rx_state_e;

    tx_state_e        tx_state_q, tx_state_d;
    rx_state_e        rx_state_q, rx_state_d;
    logic             tx_seq_q, tx_seq_d;
    logic             last_rx_seq_q, last_rx_seq_d;
    logic             rx_seq_q, rx_seq_d;
    logic [RET_W-1:0] retry_q, retry_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [RXT_W-1:0] rxt_q, rxt_d;
    logic [7:0]       move_lat_q, move_lat_d;
    logic             ack_pend_q, ack_pend_d;
    logic             ack_seq_q, ack_seq_d;
    logic             tx_trig_q, tx_trig_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic [7:0]       move_q, move_d;
    logic             move_valid_q, move_valid_d;
    logic             busy_q, busy_d;
    logic             fail_q, fail_d;

    logic rx_data_hdr_c, ack_match_c, hdr_req_c, ack_pend_c, ack_seq_c;

    assign rx_data_hdr_c = lnk.rx_ready_in && (rx_state_q == R_IDLE)
                           && (lnk.rx_byte_in[7:1] == DATA_PFX);
    assign ack_match_c   = lnk.rx_ready_in && (rx_state_q == R_IDLE)
                           && (lnk.rx_byte_in == {ACK_PFX, tx_seq_q});

    assign lnk.tx_trigger_out = tx_trig_q;
    assign lnk.tx_byte_out    = tx_byte_q;
    assign lnk.move_valid_out = move_valid_q;
    assign lnk.move_out       = move_q;
    assign lnk.link_busy_out  = busy_q;
    assign lnk.link_fail_out  = fail_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            tx_state_q    <= IDLE;
            rx_state_q    <= R_IDLE;
            tx_seq_q      <= 1'b0;
            last_rx_seq_q <= 1'b1;
            rx_seq_q      <= 1'b0;
            retry_q       <= '0;
            gap_q         <= '0;
            to_q          <= '0;
            rxt_q         <= '0;
            move_lat_q    <= '0;
            ack_pend_q    <= 1'b0;
            ack_seq_q     <= 1'b0;
            tx_trig_q     <= 1'b0;
            tx_byte_q     <= '0;
            move_q        <= '0;
            move_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            fail_q        <= 1'b0;
        end else begin
            tx_state_q    <= tx_state_d;
            rx_state_q    <= rx_state_d;
            tx_seq_q      <= tx_seq_d;
            last_rx_seq_q <= last_rx_seq_d;
            rx_seq_q      <= rx_seq_d;
            retry_q       <= retry_d;
            gap_q         <= gap_d;
            to_q          <= to_d;
            rxt_q         <= rxt_d;
            move_lat_q    <= move_lat_d;
            ack_pend_q    <= ack_pend_d;
            ack_seq_q     <= ack_seq_d;
            tx_trig_q     <= tx_trig_d;
            tx_byte_q     <= tx_byte_d;
            move_q        <= move_d;
            move_valid_q  <= move_valid_d;
            busy_q        <= busy_d;
            fail_q        <= fail_d;
        end
    end

    always_comb begin
        tx_state_d    = tx_state_q;
        rx_state_d    = rx_state_q;
        tx_seq_d      = tx_seq_q;
        last_rx_seq_d = last_rx_seq_q;
        rx_seq_d      = rx_seq_q;
        retry_d       = retry_q;
        gap_d         = gap_q;
        to_d          = to_q;
        rxt_d         = rxt_q;
        move_lat_d    = move_lat_q;
        ack_pend_c    = ack_pend_q;
        ack_seq_c     = ack_seq_q;
        tx_trig_d     = 1'b0;
        tx_byte_d     = tx_byte_q;
        move_d        = move_q;
        move_valid_d  = 1'b0;
        busy_d        = busy_q;
        fail_d        = fail_q;
        hdr_req_c     = 1'b0;

        if (gap_q != '0) gap_d = gap_q - GAP_W'(1);

        // Inbound parser; a completed frame is always acked, delivered only if new
        unique case (rx_state_q)
            R_IDLE: begin
                if (rx_data_hdr_c) begin
                    rx_seq_d   = lnk.rx_byte_in[0];
                    rxt_d      = RXT_W'(2 * BYTE_GAP_CYC);
                    rx_state_d = R_MOVE;
                end
            end
            R_MOVE: begin
                if (lnk.rx_ready_in) begin
                    ack_pend_c = 1'b1;
                    ack_seq_c  = rx_seq_q;
                    rx_state_d = R_IDLE;
                    if (rx_seq_q != last_rx_seq_q) begin
                        move_d        = lnk.rx_byte_in;
                        move_valid_d  = 1'b1;
                        last_rx_seq_d = rx_seq_q;
                    end
                end else if (rxt_q == '0) begin
                    rx_state_d = R_IDLE;
                end else begin
                    rxt_d = rxt_q - RXT_W'(1);
                end
            end
            default: rx_state_d = R_IDLE;
        endcase
        ack_pend_d = ack_pend_c;
        ack_seq_d  = ack_seq_c;

        unique case (tx_state_q)
            IDLE: begin
                if (lnk.send_in) begin
                    move_lat_d = lnk.move_in;
                    retry_d    = '0;
                    fail_d     = 1'b0;
                    busy_d     = 1'b1;
                    hdr_req_c  = 1'b1;
                end
            end
            HDR: hdr_req_c = 1'b1;
            MOVE: begin
                if (gap_q == '0) begin
                    tx_trig_d  = 1'b1;
                    tx_byte_d  = move_lat_q;
                    gap_d      = GAP_W'(BYTE_GAP_CYC - 1);
                    to_d       = TO_W'(ACK_TIMEOUT_CYC);
                    tx_state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack_match_c) begin
                    tx_seq_d   = ~tx_seq_q;
                    busy_d     = 1'b0;
                    tx_state_d = IDLE;
                end else if (to_q != '0) begin
                    to_d = to_q - TO_W'(1);
                end else if (retry_q < RET_W'(MAX_RETRIES)) begin
                    retry_d   = retry_q + RET_W'(1);
                    hdr_req_c = 1'b1;
                end else begin
                    fail_d     = 1'b1;
                    busy_d     = 1'b0;
                    tx_state_d = IDLE;
                end
            end
            default: tx_state_d = IDLE;
        endcase

        // The trigger is registered, so the gap reload is one short of the spacing
        if (hdr_req_c) begin
            if ((gap_q == '0) && !ack_pend_c) begin
                tx_trig_d  = 1'b1;
                tx_byte_d  = {DATA_PFX, tx_seq_q};
                gap_d      = GAP_W'(BYTE_GAP_CYC - 1);
                tx_state_d = MOVE;
            end else begin
                tx_state_d = HDR;
            end
        end

        // Acks go first but never between a header and its move byte
        if (ack_pend_c && (gap_q == '0) && (tx_state_q != MOVE)) begin
            tx_trig_d  = 1'b1;
            tx_byte_d  = {ACK_PFX, ack_seq_c};
            gap_d      = GAP_W'(BYTE_GAP_CYC - 1);
            ack_pend_d = 1'b0;
        end
    end
endmodule
